mulpop_arbiter: RTL and testbench

Request arbiter and sequencer for the shared 24×24 multiply + popcount execution unit (EU) behind the GPIO bus window. Two requesters (bus-side register front end and a local DMA-style job source) submit operand pairs through valid/ready handshakes. The block grants one job at a time round-robin, drives the EU start/done handshake, guards it with a watchdog, and returns the tagged result, ones count and status to the winning requester. It also maintains the 16-bit completed-operation counter shown on gpio_out.

---
 rtl/mulpop_pkg.sv | 16 +
 rtl/mulpop_arbiter_rr_arb2.sv | 21 ++
 rtl/mulpop_arbiter.sv | 127 ++++++++++++
 tb/tb_mulpop_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mulpop_pkg.sv
// Shared types and constants for the multiply/popcount arbiter slice.
package mulpop_pkg;
  localparam int OPW  = 24;
  localparam int RESW = 32;

  localparam logic [1:0] ST_OK  = 2'b11;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/mulpop_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr;

  // ptr names the requester that wins a tie.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) ptr <= 1'b0;
    else if (accept) ptr <= ~grant[1];
  end
endmodule

// File: rtl/mulpop_arbiter.sv
// Arbitrates two requesters onto the shared multiply/popcount EU, sequences the
// EU start/done handshake under a watchdog and returns the result to the winner.
module mulpop_arbiter
  import mulpop_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OPW-1:0]  req_a1,
  input  logic [2*OPW-1:0]  req_a2,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [RESW-1:0]   rsp_result,
  output logic [5:0]        rsp_ones,
  output logic [1:0]        rsp_status,
  output logic              eu_start,
  output logic [OPW-1:0]    eu_a1,
  output logic [OPW-1:0]    eu_a2,
  input  logic              eu_done,
  input  logic [RESW-1:0]   eu_result,
  input  logic              eu_ovf,
  input  logic [5:0]        eu_ones,
  output logic              busy,
  output logic [15:0]       op_count,
  output state_t            state_dbg
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t         state, state_nx;
  logic [1:0]     grant;
  logic           accept;
  logic           id;
  logic [WDW-1:0] wdog;
  logic           timed_out;
  logic [15:0]    count_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .req     (req_valid),
    .accept  (accept),
    .grant   (grant)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready may depend combinationally on valid, never the reverse.
  assign accept    = |(req_valid & req_ready);
  assign timed_out = (wdog == WDW'(TIMEOUT));
  assign busy      = (state != IDLE);
  assign op_count  = count_q;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    eu_start  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        eu_start = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (eu_done || timed_out) state_nx = RESP;
      end
      RESP: begin
        rsp_valid[id] = 1'b1;
        if (rsp_ready[id]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      id         <= 1'b0;
      eu_a1      <= '0;
      eu_a2      <= '0;
      wdog       <= '0;
      rsp_result <= '0;
      rsp_ones   <= '0;
      rsp_status <= ST_TMO;
      count_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id    <= grant[1];
            eu_a1 <= grant[1] ? req_a1[2*OPW-1:OPW] : req_a1[OPW-1:0];
            eu_a2 <= grant[1] ? req_a2[2*OPW-1:OPW] : req_a2[OPW-1:0];
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          // A done arriving on the watchdog's last cycle still counts as success.
          if (eu_done) begin
            rsp_result <= eu_result;
            rsp_ones   <= eu_ones;
            rsp_status <= eu_ovf ? ST_OVF : ST_OK;
          end else if (timed_out) begin
            rsp_result <= '0;
            rsp_ones   <= '0;
            rsp_status <= ST_TMO;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[id]) count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mulpop_arbiter.sv
// Bench for mulpop_arbiter: vector table, hand-written corner sequences and a randomized run.
module tb_mulpop_arbiter;
  import mulpop_pkg::*;

  localparam int TMO = 8;

  logic        clk;
  logic        n_reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_status;
  logic [47:0] req_a1, req_a2;
  logic [31:0] rsp_result, eu_result;
  logic [5:0]  rsp_ones, eu_ones;
  logic        eu_start, eu_done, eu_ovf, busy;
  logic [23:0] eu_a1, eu_a2;
  logic [15:0] op_count;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int eu_lat = 1;
  bit eu_hang = 0;

  logic [40:0] exp_q[$];

  typedef struct {
    logic [1:0]  v;
    logic [23:0] a1;
    logic [23:0] a2;
    logic [1:0]  e_grant;
    logic [31:0] e_res;
    logic [5:0]  e_ones;
    logic [1:0]  e_st;
    int          lat;
    int          hold;
  } vec_t;

  mulpop_arbiter #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a1     (req_a1),
    .req_a2     (req_a2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ones   (rsp_ones),
    .rsp_status (rsp_status),
    .eu_start   (eu_start),
    .eu_a1      (eu_a1),
    .eu_a2      (eu_a2),
    .eu_done    (eu_done),
    .eu_result  (eu_result),
    .eu_ovf     (eu_ovf),
    .eu_ones    (eu_ones),
    .busy       (busy),
    .op_count   (op_count),
    .state_dbg  (state_dbg)
  );

  // Clock and global time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end of test, want finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural EU: real product, configurable latency, or a hang with a late done.
  initial begin
    logic [23:0] ca1, ca2;
    logic [47:0] prod;
    eu_done = 1'b0; eu_result = '0; eu_ovf = 1'b0; eu_ones = '0;
    forever begin
      @(negedge clk);
      if (eu_start) begin
        ca1 = eu_a1;
        ca2 = eu_a2;
        if (eu_hang) begin
          repeat (TMO + 4) @(negedge clk);
          eu_result = 32'hDEADBEEF; eu_ovf = 1'b1; eu_ones = 6'd24;
        end else begin
          repeat (eu_lat) @(negedge clk);
          prod = 48'(ca1) * 48'(ca2);
          eu_result = prod[31:0];
          eu_ovf    = |prod[47:32];
          eu_ones   = 6'($countones(prod[31:0]));
          check("eu_a1_stable", 64'(eu_a1), 64'(ca1));
          check("eu_a2_stable", 64'(eu_a2), 64'(ca2));
        end
        eu_done = 1'b1;
        @(negedge clk);
        eu_done = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"}, 64'(req_ready), 64'(0));
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, " rsp_result"}, 64'(rsp_result), 64'(0));
    check({tag, " rsp_ones"}, 64'(rsp_ones), 64'(0));
    check({tag, " rsp_status"}, 64'(rsp_status), 64'(0));
    check({tag, " eu_start"}, 64'(eu_start), 64'(0));
    check({tag, " eu_a1"}, 64'(eu_a1), 64'(0));
    check({tag, " eu_a2"}, 64'(eu_a2), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " op_count"}, 64'(op_count), 64'(0));
    check({tag, " state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!(|rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rsp_seen"}, 64'(|rsp_valid), 64'(1));
  endtask

  // One full job: request, EU latency, optional stall with the other ready high, handshake.
  task automatic run_job(input string tag, input logic [1:0] v,
                         input logic [23:0] a1_0, input logic [23:0] a2_0,
                         input logic [23:0] a1_1, input logic [23:0] a2_1,
                         input logic [1:0] e_grant, input logic [31:0] e_res,
                         input logic [5:0] e_ones, input logic [1:0] e_st,
                         input int lat, input int hold, input logic [15:0] e_cnt);
    @(negedge clk);
    eu_lat    = lat;
    req_a1    = {a1_1, a1_0};
    req_a2    = {a2_1, a2_0};
    req_valid = v;
    #1 check({tag, " req_ready"}, 64'(req_ready), 64'(e_grant));
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(tag);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(e_grant));
    check({tag, " rsp_result"}, 64'(rsp_result), 64'(e_res));
    check({tag, " rsp_ones"}, 64'(rsp_ones), 64'(e_ones));
    check({tag, " rsp_status"}, 64'(rsp_status), 64'(e_st));
    check({tag, " busy"}, 64'(busy), 64'(1));
    req_valid = 2'b11;
    rsp_ready = ~e_grant;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check({tag, " hold_result"}, 64'(rsp_result), 64'(e_res));
      check({tag, " hold_valid"}, 64'(rsp_valid), 64'(e_grant));
      check({tag, " hold_req_ready"}, 64'(req_ready), 64'(0));
      check({tag, " hold_eu_start"}, 64'(eu_start), 64'(0));
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = e_grant;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check({tag, " op_count"}, 64'(op_count), 64'(e_cnt));
    check({tag, " idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    vec_t        tbl[5];
    int          cnt;
    int          winner;
    int          m_pref;
    logic [15:0] m_cnt;
    logic [1:0]  v;
    logic [23:0] x1, x2, y1, y2, w1, w2;
    logic [47:0] prod;
    logic [40:0] e;

    tbl[0] = '{2'b01, 24'd3,       24'd5,       2'b01, 32'h0000000F, 6'd4,  ST_OK,  3, 0};
    tbl[1] = '{2'b11, 24'hFFFFFF,  24'hFFFFFF,  2'b10, 32'hFE000001, 6'd8,  ST_OVF, 1, 0};
    tbl[2] = '{2'b11, 24'h00FFFF,  24'h010001,  2'b01, 32'hFFFFFFFF, 6'd32, ST_OK,  2, 10};
    tbl[3] = '{2'b01, 24'h010000,  24'h010000,  2'b01, 32'h00000000, 6'd0,  ST_OVF, 1, 0};
    tbl[4] = '{2'b10, 24'h000123,  24'h000456,  2'b10, 32'h0004EDC2, 6'd10, ST_OK,  4, 0};

    n_reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; req_a1 = '0; req_a2 = '0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Vector table; the loser's operands are junk that must not reach the EU.
    for (int i = 0; i < 5; i++) begin
      w1 = 24'($urandom_range(0, 32'hFFFFFF));
      w2 = 24'($urandom_range(0, 32'hFFFFFF));
      if (tbl[i].e_grant[1])
        run_job($sformatf("vec%0d", i), tbl[i].v, w1, w2, tbl[i].a1, tbl[i].a2, tbl[i].e_grant,
                tbl[i].e_res, tbl[i].e_ones, tbl[i].e_st, tbl[i].lat, tbl[i].hold, 16'(i + 1));
      else
        run_job($sformatf("vec%0d", i), tbl[i].v, tbl[i].a1, tbl[i].a2, w1, w2, tbl[i].e_grant,
                tbl[i].e_res, tbl[i].e_ones, tbl[i].e_st, tbl[i].lat, tbl[i].hold, 16'(i + 1));
    end

    // Watchdog expiry, then a late done that must not disturb the held response.
    @(negedge clk);
    eu_hang = 1'b1;
    req_a1 = {24'd9, 24'd2};
    req_a2 = {24'd9, 24'd3};
    req_valid = 2'b01;
    #1 check("tmo req_ready", 64'(req_ready), 64'(2'b01));
    @(posedge clk);
    #1 check("tmo eu_start_high", 64'(eu_start), 64'(1));
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    #1 check("tmo eu_start_low", 64'(eu_start), 64'(0));
    cnt = 0;
    while (!(|rsp_valid) && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("tmo latency", 64'(cnt), 64'(TMO + 1));
    check("tmo rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("tmo status", 64'(rsp_status), 64'(ST_TMO));
    check("tmo result", 64'(rsp_result), 64'(0));
    check("tmo ones", 64'(rsp_ones), 64'(0));
    repeat (6) @(negedge clk);
    check("late_done result", 64'(rsp_result), 64'(0));
    check("late_done status", 64'(rsp_status), 64'(ST_TMO));
    check("late_done valid", 64'(rsp_valid), 64'(2'b01));
    eu_hang = 1'b0;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("tmo op_count", 64'(op_count), 64'(6));
    run_job("after_tmo", 2'b10, 24'd0, 24'd0, 24'd2, 24'd3, 2'b10, 32'd6, 6'd2, ST_OK, 1, 0, 16'd7);

    // Reset pulse while waiting on the EU aborts the job.
    @(negedge clk);
    eu_hang = 1'b1;
    req_a1 = {24'd4, 24'd4};
    req_a2 = {24'd4, 24'd4};
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("mid state", 64'(state_dbg), 64'(WAIT));
    n_reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    n_reset = 1'b1;
    eu_hang = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_reset op_count", 64'(op_count), 64'(0));

    // Both requesters held valid from reset: grants alternate starting with 0.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] r;
      r = 32'((i + 1) * 7);
      run_job($sformatf("alt%0d", i), 2'b11, 24'(i + 1), 24'd7, 24'(i + 1), 24'd7,
              (i % 2 == 0) ? 2'b01 : 2'b10, r, 6'($countones(r)), ST_OK, 1, 0, 16'(i + 1));
    end

    // Counter wrap: preload to the last value before rollover.
    @(negedge clk);
    dut.count_q = 16'hFFFF;
    run_job("wrap", 2'b01, 24'd1, 24'd1, 24'd0, 24'd0, 2'b01, 32'd1, 6'd1, ST_OK, 1, 0, 16'h0000);

    // Randomized jobs against a spec-level model (tie goes to the preferred requester).
    do_reset();
    m_pref = 0;
    m_cnt = 16'd0;
    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      x1 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 32'hFFFFFF));
      x2 = 24'($urandom_range(0, 32'hFFFFFF));
      y1 = 24'($urandom_range(0, 32'hFFFFFF));
      y2 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 32'h3FF));
      winner = (v == 2'b11) ? m_pref : ((v == 2'b01) ? 0 : 1);
      m_pref = 1 - winner;
      prod = (winner == 1) ? 48'(y1) * 48'(y2) : 48'(x1) * 48'(x2);
      m_cnt = m_cnt + 16'd1;
      exp_q.push_back({winner[0], (prod >= 48'h1_0000_0000) ? ST_OVF : ST_OK,
                       6'($countones(prod[31:0])), prod[31:0]});
      e = exp_q.pop_front();
      run_job($sformatf("rnd%0d", i), v, x1, x2, y1, y2, e[40] ? 2'b10 : 2'b01,
              e[31:0], e[37:32], e[39:38], $urandom_range(1, 4), $urandom_range(0, 3), m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
